dcache_port_sched: RTL and testbench
====================================

// Module: dcache_port_sched
// PURPOSE
//  Single-port DCache scheduler between MEM1 stage and DCache. Stores are posted into an
//  in-order store buffer and drained in background; loads get priority over drains. Drives
//  dcache_busy to the MEM stage while a load is outstanding. One DCache transaction in flight.
// PARAMETERS
//  SB_DEPTH  4   store-buffer entries (power of 2, >=2); pointers wrap modulo SB_DEPTH
// PORTS
//  clk             in   1   clock
//  resetn          in   1   synchronous reset, active low
//  ex_flush        in   1   pipeline flush (exception/eret)
//  m1_req_valid    in   1   MEM1 access request
//  m1_req_wr       in   1   1=store, 0=load
//  m1_req_addr     in   32  physical byte address
//  m1_req_wstrb    in   4   store byte enables
//  m1_req_wdata    in   32  store data (byte-lane aligned)
//  m1_req_ready    out  1   request accepted this cycle
//  m1_rdata_valid  out  1   load data valid (one-cycle pulse)
//  m1_rdata        out  32  load data (raw word; MEM/WB does extension)
//  dcache_busy     out  1   load outstanding; MEM stage stalls
//  dc_req_valid    out  1   DCache request
//  dc_req_wr       out  1   DCache write
//  dc_req_addr     out  32  DCache address
//  dc_req_wstrb    out  4   DCache byte enables (0 for loads)
//  dc_req_wdata    out  32  DCache write data
//  dc_req_ready    in   1   DCache address accepted (addr_ok)
//  dc_rdata_valid  in   1   DCache response (data_ok), for reads and writes
//  dc_rdata        in   32  DCache read data
// BEHAVIOUR
//  Reset (resetn=0 at clk edge): state=IDLE, SB emptied (count=0, ptrs=0); all outputs 0.
//  Reset mid-transaction abandons it; late dc_rdata_valid after reset is ignored in IDLE.
//  Store buffer: entries {addr[31:2],wstrb,wdata}; sb_count 0..SB_DEPTH; full when =SB_DEPTH.
//  m1_req_ready (comb): !ex_flush && state==IDLE-or-drain-compatible, specifically:
//   store: sb_count<SB_DEPTH (full blocks enqueue even if dequeue same cycle).
//   load : state==IDLE && no valid SB entry with addr[31:2]==m1_req_addr[31:2].
//  Store accepted -> written to SB tail same edge; never sent directly to DCache.
//  FSM: IDLE, LD_REQ, LD_WAIT, DR_REQ, DR_WAIT.
//   IDLE: load accepted -> LD_REQ (latched addr); else sb_count>0 -> DR_REQ; else stay.
//   LD_REQ: dc_req_valid=1,wr=0,wstrb=0; dc_req_ready -> LD_WAIT; ex_flush before
//     handshake -> IDLE (request dropped).
//   LD_WAIT: dc_rdata_valid -> m1_rdata_valid=1 (unless flush_pending), m1_rdata=dc_rdata
//     same cycle (comb), -> IDLE. ex_flush here sets flush_pending; data consumed, discarded.
//   DR_REQ: drive SB head; dc_req_ready -> DR_WAIT. Not abortable by ex_flush.
//   DR_WAIT: dc_rdata_valid -> pop head (count-1, head+1), -> IDLE.
//  Priority in IDLE: accepted load > drain. Drains may start only from IDLE, so a pending load
//   waits at most one drain transaction.
//  Load/SB hazard: matching-word load stalls (ready=0) until matching entries drain; no forwarding.
//  dcache_busy = state in {LD_REQ,LD_WAIT} && !dc_rdata_valid; also 1 when m1_req_valid load
//   is presented but not accepted. Low in cycle m1_rdata_valid pulses.
//  Latency: load accepted T -> dc_req_valid T+1 -> earliest data T+2 (DCache 1-cycle).
//  Simultaneous store enqueue and drain pop: count unchanged, both ptrs advance.
//  dc_req_* outputs held stable while dc_req_valid && !dc_req_ready.
// TESTING
//  1 Load 0x80001000, SB empty, DCache 1-cycle -> dc_req_valid T+1, m1_rdata_valid T+2 data.
//  2 Four stores 0x100,0x104,0x108,0x10C back-to-back, DCache stalled -> 5th store ready=0,
//    after one DR_WAIT completion 5th accepted; drains in order 0x100..0x10C, 0x110.
//  3 Store 0x200 wstrb=0011 buffered, then load 0x202 -> ready=0 until 0x200 drained, then
//    load issues and returns updated word.
//  4 Load 0x300 issued while SB has 2 non-matching stores -> load on DCache before drains.
//  5 ex_flush during LD_WAIT -> dc_rdata_valid consumed, m1_rdata_valid stays 0, FSM IDLE.
//  6 resetn=0 in DR_WAIT with 3 entries -> next cycle count=0, all outputs 0, IDLE.

Source files
------------

// File: rtl/dcache_port_sched_if.sv
// Handshake bundle between the MEM1 stage, the DCache port scheduler and the DCache.
// The scheduler sits on the slave modport; the surrounding pipeline/DCache use master.
interface dcache_port_sched_if;
    logic        ex_flush;
    logic        m1_req_valid;
    logic        m1_req_wr;
    logic [31:0] m1_req_addr;
    logic [3:0]  m1_req_wstrb;
    logic [31:0] m1_req_wdata;
    logic        m1_req_ready;
    logic        m1_rdata_valid;
    logic [31:0] m1_rdata;
    logic        dcache_busy;
    logic        dc_req_valid;
    logic        dc_req_wr;
    logic [31:0] dc_req_addr;
    logic [3:0]  dc_req_wstrb;
    logic [31:0] dc_req_wdata;
    logic        dc_req_ready;
    logic        dc_rdata_valid;
    logic [31:0] dc_rdata;

    modport slave (
        input  ex_flush, m1_req_valid, m1_req_wr, m1_req_addr, m1_req_wstrb, m1_req_wdata,
               dc_req_ready, dc_rdata_valid, dc_rdata,
        output m1_req_ready, m1_rdata_valid, m1_rdata, dcache_busy,
               dc_req_valid, dc_req_wr, dc_req_addr, dc_req_wstrb, dc_req_wdata
    );

    modport master (
        output ex_flush, m1_req_valid, m1_req_wr, m1_req_addr, m1_req_wstrb, m1_req_wdata,
               dc_req_ready, dc_rdata_valid, dc_rdata,
        input  m1_req_ready, m1_rdata_valid, m1_rdata, dcache_busy,
               dc_req_valid, dc_req_wr, dc_req_addr, dc_req_wstrb, dc_req_wdata
    );
endinterface

// File: rtl/dcache_port_sched.sv
// Single-port DCache scheduler: loads go straight to the DCache, stores are posted into an
// in-order store buffer and drained in the background whenever no load is waiting.
module dcache_port_sched #(
    parameter int SB_DEPTH = 4
) (
    input  logic                clk,
    input  logic                resetn,
    dcache_port_sched_if.slave  bus
);
    localparam int PW = $clog2(SB_DEPTH);

    typedef enum logic [2:0] {IDLE, LD_REQ, LD_WAIT, DR_REQ, DR_WAIT} state_t;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } dc_req_t;

    state_t        state;
    dc_req_t       dc_req_q;
    logic          dc_req_valid_q;
    logic          flush_pending;

    logic [29:0]   sb_addr  [SB_DEPTH];
    logic [3:0]    sb_wstrb [SB_DEPTH];
    logic [31:0]   sb_wdata [SB_DEPTH];
    logic [PW-1:0] sb_head;
    logic [PW-1:0] sb_tail;
    logic [PW:0]   sb_count;

    logic sb_full;
    logic ld_hit;
    logic ld_accept;
    logic st_accept;
    logic sb_pop;
    logic ld_done;
    logic ld_data_valid;

    assign sb_full = (sb_count == (PW+1)'(SB_DEPTH));

    // A load may not bypass a buffered store to the same word; there is no forwarding path.
    always_comb begin
        logic [PW-1:0] off;
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        ld_hit = 1'b0;
        off    = '0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            off = PW'(i) - sb_head;
            if (({1'b0, off} < sb_count) && (sb_addr[i] == bus.m1_req_addr[31:2]))
                ld_hit = 1'b1;
        end
    end

    assign bus.m1_req_ready = bus.m1_req_valid && !bus.ex_flush &&
                              (bus.m1_req_wr ? !sb_full : (state == IDLE && !ld_hit));
    assign ld_accept = bus.m1_req_ready && !bus.m1_req_wr;
    assign st_accept = bus.m1_req_ready &&  bus.m1_req_wr;
    assign sb_pop    = (state == DR_WAIT) && bus.dc_rdata_valid;
    assign ld_done   = (state == LD_WAIT) && bus.dc_rdata_valid;

    // Data for a flushed load is still consumed from the DCache, just never reported.
    assign ld_data_valid      = ld_done && !flush_pending && !bus.ex_flush;
    assign bus.m1_rdata_valid = ld_data_valid;
    assign bus.m1_rdata       = ld_done ? bus.dc_rdata : '0;
    assign bus.dcache_busy    = !ld_data_valid &&
        ((((state == LD_REQ) || (state == LD_WAIT)) && !bus.dc_rdata_valid) ||
         (bus.m1_req_valid && !bus.m1_req_wr && !bus.m1_req_ready));

    assign bus.dc_req_valid = dc_req_valid_q;
    assign bus.dc_req_wr    = dc_req_q.wr;
    assign bus.dc_req_addr  = dc_req_q.addr;
    assign bus.dc_req_wstrb = dc_req_q.wstrb;
    assign bus.dc_req_wdata = dc_req_q.wdata;

    // NOTE: buffer storage is not reset; head/tail/count alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (st_accept) begin
            sb_addr[sb_tail]  <= bus.m1_req_addr[31:2];
            sb_wstrb[sb_tail] <= bus.m1_req_wstrb;
            sb_wdata[sb_tail] <= bus.m1_req_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sb_head  <= '0;
            sb_tail  <= '0;
            sb_count <= '0;
        end else begin
            if (st_accept) sb_tail <= sb_tail + PW'(1);
            if (sb_pop)    sb_head <= sb_head + PW'(1);
            sb_count <= sb_count + (PW+1)'(st_accept) - (PW+1)'(sb_pop);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state          <= IDLE;
            dc_req_valid_q <= 1'b0;
            dc_req_q       <= '0;
            flush_pending  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    flush_pending <= 1'b0;
                    if (ld_accept) begin
                        state          <= LD_REQ;
                        dc_req_valid_q <= 1'b1;
                        dc_req_q       <= '{wr: 1'b0, addr: bus.m1_req_addr, wstrb: 4'b0, wdata: 32'b0};
                    end else if (sb_count != '0) begin
                        state          <= DR_REQ;
                        dc_req_valid_q <= 1'b1;
                        dc_req_q       <= '{wr: 1'b1, addr: {sb_addr[sb_head], 2'b00},
                                            wstrb: sb_wstrb[sb_head], wdata: sb_wdata[sb_head]};
                    end
                end
                LD_REQ: begin
                    // Once the DCache has taken the address the response must still be absorbed.
                    if (bus.dc_req_ready) begin
                        state          <= LD_WAIT;
                        flush_pending  <= bus.ex_flush;
                        dc_req_valid_q <= 1'b0;
                        dc_req_q       <= '0;
                    end else if (bus.ex_flush) begin
                        state          <= IDLE;
                        dc_req_valid_q <= 1'b0;
                        dc_req_q       <= '0;
                    end
                end
                LD_WAIT: begin
                    if (bus.ex_flush)       flush_pending <= 1'b1;
                    if (bus.dc_rdata_valid) state         <= IDLE;
                end
                DR_REQ: begin
                    if (bus.dc_req_ready) begin
                        state          <= DR_WAIT;
                        dc_req_valid_q <= 1'b0;
                        dc_req_q       <= '0;
                    end
                end
                DR_WAIT: begin
                    if (bus.dc_rdata_valid) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dcache_port_sched.sv
// Directed bench for dcache_port_sched with a small 1-cycle DCache memory model and a
// handshake log used to check issue order.
module tb_dcache_port_sched;
    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    dcache_port_sched_if bus();

    dcache_port_sched #(.SB_DEPTH(4)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    // DCache model: unwritten words read as {16'hDEAD, addr[15:0]}; one response a cycle later.
    logic        accept_en;
    logic        resp_en;
    logic        pend = 1'b0;
    logic [31:0] pend_data = '0;
    logic [32:0] log_q[$];
    logic [31:0] mem [logic [29:0]];

    assign bus.dc_req_ready   = accept_en;
    assign bus.dc_rdata_valid = pend && resp_en;
    assign bus.dc_rdata       = pend_data;

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        if (mem.exists(a[31:2])) return mem[a[31:2]];
        return {16'hDEAD, a[15:2], 2'b00};
    endfunction

    always @(posedge clk) begin
        logic [31:0] w;
        if (bus.dc_rdata_valid) pend <= 1'b0;
        if (bus.dc_req_valid && bus.dc_req_ready) begin
            pend <= 1'b1;
            log_q.push_back({bus.dc_req_wr, bus.dc_req_addr});
            if (bus.dc_req_wr) begin
                w = rd_word(bus.dc_req_addr);
                for (int b = 0; b < 4; b++)
                    if (bus.dc_req_wstrb[b]) w[8*b +: 8] = bus.dc_req_wdata[8*b +: 8];
                mem[bus.dc_req_addr[31:2]] = w;
                pend_data <= '0;
            end else begin
                pend_data <= rd_word(bus.dc_req_addr);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic wr, input logic [31:0] addr, input logic [3:0] strb,
                         input logic [31:0] data);
        bus.m1_req_valid = 1'b1;
        bus.m1_req_wr    = wr;
        bus.m1_req_addr  = addr;
        bus.m1_req_wstrb = strb;
        bus.m1_req_wdata = data;
    endtask

    task automatic idle_req();
        bus.m1_req_valid = 1'b0;
        bus.m1_req_wr    = 1'b0;
        bus.m1_req_addr  = '0;
        bus.m1_req_wstrb = '0;
        bus.m1_req_wdata = '0;
    endtask

    // Called at the negedge of the cycle a load was accepted; expects data two cycles later.
    task automatic wait_load(input string tag, input logic [31:0] exp_data);
        int lat = 99;
        for (int i = 1; i <= 20; i++) begin
            next_cycle();
            if (i == 1) idle_req();
            @(negedge clk);
            if (bus.m1_rdata_valid) begin
                lat = i;
                break;
            end
        end
        check({tag, "_lat"}, lat, 2);
        check({tag, "_data"}, bus.m1_rdata, exp_data);
    endtask

    task automatic wait_log(input string tag, input int n);
        for (int i = 0; i < 60; i++) begin
            if (log_q.size() >= n) break;
            next_cycle();
        end
        check({tag, "_cnt"}, log_q.size(), n);
    endtask

    initial begin
        int stalls;
        resetn       = 1'b0;
        bus.ex_flush = 1'b0;
        accept_en    = 1'b1;
        resp_en      = 1'b1;
        idle_req();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_dc_valid", bus.dc_req_valid, 0);
        check("rst_rdata_valid", bus.m1_rdata_valid, 0);
        check("rst_busy", bus.dcache_busy, 0);
        check("rst_ready", bus.m1_req_ready, 0);
        resetn = 1'b1;
        next_cycle();

        // 1: plain load, SB empty
        drive(1'b0, 32'h8000_1000, 4'h0, 32'h0);
        @(negedge clk);
        check("t1_ready", bus.m1_req_ready, 1);
        check("t1_busy_acc", bus.dcache_busy, 0);
        next_cycle();
        idle_req();
        @(negedge clk);
        check("t1_dc_valid", bus.dc_req_valid, 1);
        check("t1_dc_addr", bus.dc_req_addr, 32'h8000_1000);
        check("t1_dc_wr", bus.dc_req_wr, 0);
        check("t1_dc_wstrb", bus.dc_req_wstrb, 0);
        check("t1_busy_req", bus.dcache_busy, 1);
        next_cycle();
        @(negedge clk);
        check("t1_rvalid", bus.m1_rdata_valid, 1);
        check("t1_rdata", bus.m1_rdata, 32'hDEAD_1000);
        check("t1_busy_data", bus.dcache_busy, 0);
        next_cycle();
        @(negedge clk);
        check("t1_rvalid_pulse", bus.m1_rdata_valid, 0);
        check("t1_dc_idle", bus.dc_req_valid, 0);
        next_cycle();

        // 2: fill the SB with the DCache stalled, then drain in order
        log_q.delete();
        accept_en = 1'b0;
        drive(1'b1, 32'h100, 4'hF, 32'h1111_1111);
        @(negedge clk); check("t2_rdy0", bus.m1_req_ready, 1);
        next_cycle();
        drive(1'b1, 32'h104, 4'hF, 32'h2222_2222);
        @(negedge clk); check("t2_rdy1", bus.m1_req_ready, 1);
        next_cycle();
        drive(1'b1, 32'h108, 4'hF, 32'h3333_3333);
        @(negedge clk);
        check("t2_rdy2", bus.m1_req_ready, 1);
        check("t2_dc_valid", bus.dc_req_valid, 1);
        check("t2_dc_wr", bus.dc_req_wr, 1);
        check("t2_dc_addr", bus.dc_req_addr, 32'h100);
        check("t2_dc_wdata", bus.dc_req_wdata, 32'h1111_1111);
        check("t2_dc_wstrb", bus.dc_req_wstrb, 4'hF);
        next_cycle();
        drive(1'b1, 32'h10C, 4'hF, 32'h4444_4444);
        @(negedge clk); check("t2_rdy3", bus.m1_req_ready, 1);
        next_cycle();
        drive(1'b1, 32'h110, 4'hF, 32'h5555_5555);
        @(negedge clk);
        check("t2_full", bus.m1_req_ready, 0);
        check("t2_hold_addr", bus.dc_req_addr, 32'h100);
        check("t2_busy_store", bus.dcache_busy, 0);
        accept_en = 1'b1;
        next_cycle();
        @(negedge clk); check("t2_full_pop", bus.m1_req_ready, 0);
        next_cycle();
        @(negedge clk); check("t2_fifth", bus.m1_req_ready, 1);
        next_cycle();
        idle_req();
        wait_log("t2_log", 5);
        if (log_q.size() >= 5) begin
            for (int i = 0; i < 5; i++) begin
                check($sformatf("t2_ord%0d_addr", i), log_q[i][31:0], 32'h100 + 32'(4 * i));
                check($sformatf("t2_ord%0d_wr", i), 32'(log_q[i][32]), 1);
            end
        end
        repeat (3) next_cycle();

        // 3: load to a word with a buffered partial store waits for the drain
        log_q.delete();
        drive(1'b1, 32'h200, 4'b0011, 32'h1234_BEEF);
        @(negedge clk); check("t3_st_ready", bus.m1_req_ready, 1);
        stalls = 0;
        for (int i = 0; i < 20; i++) begin
            next_cycle();
            drive(1'b0, 32'h202, 4'h0, 32'h0);
            @(negedge clk);
            if (i == 0) check("t3_busy", bus.dcache_busy, 1);
            if (bus.m1_req_ready) break;
            stalls++;
        end
        check("t3_stalls", stalls, 3);
        wait_load("t3", 32'hDEAD_BEEF);
        repeat (3) next_cycle();

        // 4: a load beats two buffered non-matching stores to the DCache
        log_q.delete();
        resp_en = 1'b0;
        drive(1'b0, 32'h500, 4'h0, 32'h0);
        @(negedge clk); check("t4_ld0_ready", bus.m1_req_ready, 1);
        next_cycle();
        drive(1'b1, 32'h400, 4'hF, 32'h4040_4040);
        @(negedge clk); check("t4_st0_ready", bus.m1_req_ready, 1);
        next_cycle();
        drive(1'b1, 32'h404, 4'hF, 32'h4141_4141);
        @(negedge clk);
        check("t4_st1_ready", bus.m1_req_ready, 1);
        check("t4_busy_wait", bus.dcache_busy, 1);
        next_cycle();
        drive(1'b0, 32'h300, 4'h0, 32'h0);
        resp_en = 1'b1;
        @(negedge clk);
        check("t4_ld0_rvalid", bus.m1_rdata_valid, 1);
        check("t4_ld0_rdata", bus.m1_rdata, 32'hDEAD_0500);
        check("t4_ld1_blocked", bus.m1_req_ready, 0);
        next_cycle();
        @(negedge clk); check("t4_ld1_ready", bus.m1_req_ready, 1);
        wait_load("t4_ld1", 32'hDEAD_0300);
        wait_log("t4_log", 4);
        if (log_q.size() >= 4) begin
            check("t4_ord1", log_q[1], {1'b0, 32'h300});
            check("t4_ord2", log_q[2], {1'b1, 32'h400});
            check("t4_ord3", log_q[3], {1'b1, 32'h404});
        end
        repeat (3) next_cycle();

        // 5: flush while waiting for load data
        resp_en = 1'b0;
        drive(1'b0, 32'h600, 4'h0, 32'h0);
        @(negedge clk); check("t5_ready", bus.m1_req_ready, 1);
        next_cycle();
        idle_req();
        next_cycle();
        bus.ex_flush = 1'b1;
        @(negedge clk); check("t5_busy_wait", bus.dcache_busy, 1);
        next_cycle();
        bus.ex_flush = 1'b0;
        resp_en      = 1'b1;
        @(negedge clk);
        check("t5_rvalid", bus.m1_rdata_valid, 0);
        check("t5_busy", bus.dcache_busy, 0);
        next_cycle();
        drive(1'b0, 32'h604, 4'h0, 32'h0);
        @(negedge clk); check("t5_idle_ready", bus.m1_req_ready, 1);
        wait_load("t5_next", 32'hDEAD_0604);
        repeat (3) next_cycle();

        // 6: reset while a drain is outstanding with three entries buffered
        log_q.delete();
        resp_en = 1'b0;
        drive(1'b1, 32'h700, 4'hF, 32'hA7A7_A7A7);
        @(negedge clk); check("t6_st0", bus.m1_req_ready, 1);
        next_cycle();
        drive(1'b1, 32'h704, 4'hF, 32'h0000_0011);
        @(negedge clk); check("t6_st1", bus.m1_req_ready, 1);
        next_cycle();
        drive(1'b1, 32'h708, 4'hF, 32'h0000_0022);
        @(negedge clk);
        check("t6_st2", bus.m1_req_ready, 1);
        check("t6_dr_addr", bus.dc_req_addr, 32'h700);
        next_cycle();
        idle_req();
        resetn = 1'b0;
        next_cycle();
        resetn = 1'b1;
        @(negedge clk);
        check("t6_dc_valid", bus.dc_req_valid, 0);
        check("t6_dc_wr", bus.dc_req_wr, 0);
        check("t6_dc_addr", bus.dc_req_addr, 0);
        check("t6_dc_wstrb", bus.dc_req_wstrb, 0);
        check("t6_dc_wdata", bus.dc_req_wdata, 0);
        check("t6_rvalid", bus.m1_rdata_valid, 0);
        check("t6_rdata", bus.m1_rdata, 0);
        check("t6_busy", bus.dcache_busy, 0);
        next_cycle();
        resp_en = 1'b1;
        @(negedge clk);
        check("t6_late_rvalid", bus.m1_rdata_valid, 0);
        check("t6_no_drain", bus.dc_req_valid, 0);
        next_cycle();
        drive(1'b0, 32'h700, 4'h0, 32'h0);
        @(negedge clk); check("t6_sb_empty", bus.m1_req_ready, 1);
        wait_load("t6_ld", 32'hA7A7_A7A7);
        repeat (5) next_cycle();
        check("t6_log_cnt", log_q.size(), 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
